// File: rtl/pc_fetch_unit_pkg.sv
// Shared RISC-V fetch definitions: datapath width, PC-source encodings and fetch FSM states.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
  localparam logic [1:0] PC_SRC_BR   = 2'b01;
  localparam logic [1:0] PC_SRC_JALR = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TRAP  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle between the fetch unit (master) and the core/instruction-memory side (slave).
interface pc_fetch_unit_if #(
  parameter int W = riscv_pkg::XLEN
) ();
  import riscv_pkg::*;

  logic         redirect_valid;
  logic [1:0]   pc_src;
  logic [W-1:0] pctarg;
  logic [W-1:0] alu_result;
  logic         stall;
  logic         imem_ready;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic [W-1:0] pc;
  logic [W-1:0] pc_plus4;
  logic         misalign_err;
  logic [W-1:0] trap_addr;

  modport master (
    input  redirect_valid, pc_src, pctarg, alu_result, stall, imem_ready,
    output imem_req, imem_addr, pc, pc_plus4, misalign_err, trap_addr
  );

  modport slave (
    output redirect_valid, pc_src, pctarg, alu_result, stall, imem_ready,
    input  imem_req, imem_addr, pc, pc_plus4, misalign_err, trap_addr
  );

endinterface

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Redirect target mux (branch/JAL, JALR, sequential) with word-alignment check.
module next_pc_sel #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [1:0]      i_pc_src,
  input  logic [XLEN-1:0] i_pctarg,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_pc_plus4,
  output logic [XLEN-1:0] o_target,
  output logic            o_misaligned
);
  import riscv_pkg::*;

  always_comb begin
    o_target = i_pc_plus4;
    case (i_pc_src)
      PC_SRC_BR:   o_target = i_pctarg;
      // JALR clears bit 0 of base+offset before use
      PC_SRC_JALR: o_target = i_alu_result & ~XLEN'(1);
      default:     o_target = i_pc_plus4;
    endcase
  end

  assign o_misaligned = (o_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and valid/ready fetch sequencer with pending-redirect capture and misalign trap.
module pc_fetch_unit #(
  parameter int              XLEN        = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              INSTR_BYTES = riscv_pkg::INSTR_BYTES
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_unit_if.master bus
);
  import riscv_pkg::*;

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_addr;
  logic            r_pend_valid;
  logic            r_misalign_err;
  logic [XLEN-1:0] r_trap_addr;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned;
  logic            w_req;
  logic            w_active;
  logic            w_accept;
  logic            w_trap_now;

  assign w_pc_plus4 = r_pc + XLEN'(INSTR_BYTES);

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .i_pc_src     (bus.pc_src),
    .i_pctarg     (bus.pctarg),
    .i_alu_result (bus.alu_result),
    .i_pc_plus4   (w_pc_plus4),
    .o_target     (w_target),
    .o_misaligned (w_misaligned)
  );

  assign w_active   = (r_state != ST_TRAP);
  assign w_accept   = ((r_state == ST_FETCH) || (r_state == ST_WAIT)) && bus.imem_ready;
  assign w_trap_now = w_active && bus.redirect_valid && w_misaligned;

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    case (r_state)
      ST_BOOT:  w_state_next = ST_FETCH;
      ST_FETCH,
      ST_WAIT: begin
        w_req        = 1'b1;
        w_state_next = bus.imem_ready ? ST_FETCH : ST_WAIT;
      end
      ST_TRAP:  w_state_next = ST_TRAP;
      default:  w_state_next = ST_BOOT;
    endcase
    if (w_trap_now) begin
      w_state_next = ST_TRAP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_BOOT;
      r_pc           <= RESET_PC;
      r_pend_valid   <= 1'b0;
      r_pend_addr    <= '0;
      r_misalign_err <= 1'b0;
      r_trap_addr    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_trap_now) begin
        r_misalign_err <= 1'b1;
        r_trap_addr    <= w_target;
        r_pend_valid   <= 1'b0;
      end else if (w_accept) begin
        // live redirect beats pending, which beats stall
        r_pend_valid <= 1'b0;
        if (bus.redirect_valid) begin
          r_pc <= w_target;
        end else if (r_pend_valid) begin
          r_pc <= r_pend_addr;
        end else if (!bus.stall) begin
          r_pc <= w_pc_plus4;
        end
      end else if (w_active && bus.redirect_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= w_target;
      end
    end
  end

  assign bus.imem_req     = w_req;
  assign bus.imem_addr    = r_pc;
  assign bus.pc           = r_pc;
  assign bus.pc_plus4     = w_pc_plus4;
  assign bus.misalign_err = r_misalign_err;
  assign bus.trap_addr    = r_trap_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector table, a hand-written trap sequence and a randomized run against a behavioural model.
module tb_pc_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pc_fetch_unit_if #(.W(32)) bus ();

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .INSTR_BYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [1:0]  src;
    logic [31:0] targ;
    logic [31:0] alu;
    logic        stall;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_err;
    logic [31:0] exp_trap;
  } vec_t;

  vec_t tbl[$];

  // behavioural model: a request is outstanding unless booting or trapped
  logic        m_booting;
  logic        m_trapped;
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_pend_addr;
  logic [31:0] m_trap_addr;

  function automatic vec_t mk(logic r, logic rd, logic [1:0] s, logic [31:0] t, logic [31:0] a,
                              logic st, logic rdy, logic er, logic [31:0] ea, logic ee, logic [31:0] et);
    vec_t v;
    v.rst_n = r; v.redir = rd; v.src = s; v.targ = t; v.alu = a; v.stall = st; v.ready = rdy;
    v.exp_req = er; v.exp_addr = ea; v.exp_err = ee; v.exp_trap = et;
    return v;
  endfunction

  task automatic drive(logic r, logic rd, logic [1:0] s, logic [31:0] t, logic [31:0] a,
                       logic st, logic rdy);
    rst_n              = r;
    bus.redirect_valid = rd;
    bus.pc_src         = s;
    bus.pctarg         = t;
    bus.alu_result     = a;
    bus.stall          = st;
    bus.imem_ready     = rdy;
  endtask

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(string tag, int idx, logic er, logic [31:0] ea, logic ee, logic [31:0] et);
    chk({tag, ".imem_req"},     idx, 32'(bus.imem_req),     32'(er));
    chk({tag, ".imem_addr"},    idx, bus.imem_addr,         ea);
    chk({tag, ".pc"},           idx, bus.pc,                ea);
    chk({tag, ".pc_plus4"},     idx, bus.pc_plus4,          ea + 32'd4);
    chk({tag, ".misalign_err"}, idx, 32'(bus.misalign_err), 32'(ee));
    chk({tag, ".trap_addr"},    idx, bus.trap_addr,         et);
  endtask

  task automatic model_step(logic r, logic rd, logic [1:0] s, logic [31:0] t, logic [31:0] a,
                            logic st, logic rdy);
    logic [31:0] tgt;
    if (!r) begin
      m_booting = 1'b1; m_trapped = 1'b0; m_pc = 32'h0; m_pend = 1'b0; m_trap_addr = 32'h0;
      return;
    end
    if (m_trapped) return;
    if (s == 2'b01)      tgt = t;
    else if (s == 2'b10) tgt = a - (a % 2);
    else                 tgt = m_pc + 32'd4;
    if (rd && (tgt % 4 != 0)) begin
      m_trapped = 1'b1; m_trap_addr = tgt; m_booting = 1'b0;
      return;
    end
    if (!m_booting && rdy) begin
      if (rd)          begin m_pc = tgt; m_pend = 1'b0; end
      else if (m_pend) begin m_pc = m_pend_addr; m_pend = 1'b0; end
      else if (!st)    m_pc = m_pc + 32'd4;
    end else if (rd) begin
      m_pend = 1'b1; m_pend_addr = tgt;
    end
    m_booting = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);

    //       rst  rd  src    pctarg        alu          stl  rdy  req  addr          err  trap
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,   0, 0,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,   0, 0,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,   0, 1,  1, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,   0, 1,  1, 32'h4,        0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,   0, 1,  1, 32'h8,        0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,   0, 1,  1, 32'hC,        0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b10, 32'h0,        32'h9,   0, 1,  1, 32'h8,        0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b01, 32'h40,       32'h0,   0, 1,  1, 32'h40,       0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b10, 32'h0,        32'h101, 0, 1,  1, 32'h100,      0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,   1, 1,  1, 32'h100,      0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b01, 32'h10,       32'h0,   1, 1,  1, 32'h10,       0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,   0, 0,  1, 32'h10,       0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b01, 32'h80,       32'h0,   0, 0,  1, 32'h10,       0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b01, 32'h90,       32'h0,   0, 0,  1, 32'h10,       0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,   0, 1,  1, 32'h90,       0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b01, 32'hA0,       32'h0,   0, 0,  1, 32'h90,       0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,   1, 1,  1, 32'hA0,       0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b01, 32'hB0,       32'h0,   0, 0,  1, 32'hA0,       0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b01, 32'hC0,       32'h0,   0, 1,  1, 32'hC0,       0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,   0, 1,  1, 32'hC4,       0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b10, 32'h0,        32'h102, 0, 1,  0, 32'hC4,       1, 32'h102));
    tbl.push_back(mk(1, 1, 2'b01, 32'h200,      32'h0,   0, 1,  0, 32'hC4,       1, 32'h102));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,   0, 1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,   0, 1,  1, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b01, 32'hFFFFFFFC, 32'h0,   0, 1,  1, 32'hFFFFFFFC, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,   0, 1,  1, 32'h0,        0, 32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].redir, tbl[i].src, tbl[i].targ, tbl[i].alu, tbl[i].stall, tbl[i].ready);
      @(posedge clk); #1;
      check_all("table", i, tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_err, tbl[i].exp_trap);
    end

    // misaligned redirect while waiting traps at once and the trap persists
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("boot", 0, 1'b1, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 2'b01, 32'h6, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("waittrap", 0, 1'b0, 32'h0, 1'b1, 32'h6);
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 1'b1, 2'b01, 32'h40, 32'h0, 1'b0, 1'b1);
      @(posedge clk); #1;
      check_all("waittrap", k, 1'b0, 32'h0, 1'b1, 32'h6);
    end

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      logic        r, rd, st, rdy;
      logic [1:0]  s;
      logic [31:0] t, a;
      r   = (i == 0) ? 1'b0 : ($urandom_range(0, m_trapped ? 3 : 99) != 0);
      rd  = ($urandom_range(0, 3) == 0);
      s   = 2'($urandom_range(0, 3));
      t   = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      a   = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive(r, rd, s, t, a, st, rdy);
      model_step(r, rd, s, t, a, st, rdy);
      @(posedge clk); #1;
      check_all("random", i, !(m_booting || m_trapped), m_pc, m_trapped, m_trap_addr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
